// File: rtl/ls_queue_multicdb.sv
// In-order load/store queue: CDB wakeup on several channels, a held issue register
// toward the LSU, and a flush that keeps the committed-store prefix.
module ls_queue_multicdb #(
  parameter int          DEPTH       = 16,
  parameter int          ROB_W       = 4,
  parameter int          OP_W        = 6,
  parameter int          LOAD_OP_MAX = 5,
  parameter int          NUM_CDB     = 2,
  parameter int          FULL_MARGIN = 2,
  parameter logic [31:0] IO_ADDR     = 32'h30000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     in_valid,
  input  logic [OP_W-1:0]          in_op,
  input  logic [31:0]              in_v1,
  input  logic [31:0]              in_v2,
  input  logic [ROB_W-1:0]         in_q1,
  input  logic [ROB_W-1:0]         in_q2,
  input  logic [31:0]              in_imm,
  input  logic [ROB_W-1:0]         in_rob_id,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OP_W-1:0]          issue_op,
  output logic [31:0]              issue_addr,
  output logic [31:0]              issue_data,
  output logic [ROB_W-1:0]         issue_rob_id,
  input  logic                     commit_valid,
  input  logic [ROB_W-1:0]         commit_rob_id,
  input  logic [ROB_W-1:0]         io_rob_id_in,
  output logic [ROB_W-1:0]         io_rob_id_out,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*32-1:0]    cdb_data,
  input  logic                     flush
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_committed;
  logic [OP_W-1:0]  ent_op  [DEPTH];
  logic [31:0]      ent_v1  [DEPTH];
  logic [31:0]      ent_v2  [DEPTH];
  logic [31:0]      ent_imm [DEPTH];
  logic [ROB_W-1:0] ent_q1  [DEPTH];
  logic [ROB_W-1:0] ent_q2  [DEPTH];
  logic [ROB_W-1:0] ent_rob [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;

  logic [32:0]      wake1 [DEPTH];
  logic [32:0]      wake2 [DEPTH];
  logic [32:0]      byp1;
  logic [32:0]      byp2;
  logic [DEPTH-1:0] commit_hit;
  logic [DEPTH-1:0] keep;
  logic [CW-1:0]    keep_count;
  logic             keep_run;
  logic [AW-1:0]    scan_idx;

  logic [31:0]      head_addr;
  logic             head_is_load;
  logic             head_ready;
  logic             out_free;
  logic             do_issue;
  logic             do_alloc;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op <= OP_W'(LOAD_OP_MAX);
  endfunction

  // Scans channels from high to low so the lowest matching channel is the one kept.
  function automatic logic [32:0] cdb_lookup(input logic [ROB_W-1:0] q,
                                             input logic [NUM_CDB-1:0] vld,
                                             input logic [NUM_CDB*ROB_W-1:0] ids,
                                             input logic [NUM_CDB*32-1:0] data);
    logic [32:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (q != '0 && vld[k] && ids[k*ROB_W +: ROB_W] == q) r = {1'b1, data[k*32 +: 32]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i]      = cdb_lookup(ent_q1[i], cdb_valid, cdb_rob_id, cdb_data);
      wake2[i]      = cdb_lookup(ent_q2[i], cdb_valid, cdb_rob_id, cdb_data);
      commit_hit[i] = commit_valid && ent_valid[i] && !ent_committed[i] &&
                      ent_rob[i] == commit_rob_id;
    end
    byp1 = cdb_lookup(in_q1, cdb_valid, cdb_rob_id, cdb_data);
    byp2 = cdb_lookup(in_q2, cdb_valid, cdb_rob_id, cdb_data);
  end

  // Committed stores surviving a flush, counting this cycle's commit as already applied.
  always_comb begin
    keep       = '0;
    keep_count = '0;
    keep_run   = 1'b1;
    scan_idx   = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + AW'(k);
      if (keep_run && ent_valid[scan_idx] && !is_load(ent_op[scan_idx]) &&
          (ent_committed[scan_idx] || commit_hit[scan_idx])) begin
        keep[scan_idx] = 1'b1;
        keep_count     = keep_count + CW'(1);
      end else begin
        keep_run = 1'b0;
      end
    end
  end

  assign head_addr    = ent_v1[head] + ent_imm[head];
  assign head_is_load = is_load(ent_op[head]);
  assign out_free     = !issue_valid || issue_ready;
  assign head_ready   = ent_valid[head] && ent_q1[head] == '0 && ent_q2[head] == '0 &&
                        (head_is_load ? (head_addr != IO_ADDR || io_rob_id_in == ent_rob[head])
                                      : ent_committed[head]);
  assign do_issue     = head_ready && out_free && !flush;
  assign do_alloc     = in_valid && count < CW'(DEPTH) && !flush;
  assign full         = count >= CW'(DEPTH - FULL_MARGIN);
  assign io_rob_id_out = (ent_valid[head] && head_is_load && ent_q1[head] == '0 &&
                          head_addr == IO_ADDR) ? ent_rob[head] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      ent_valid     <= '0;
      ent_committed <= '0;
      issue_valid   <= 1'b0;
      issue_op      <= '0;
      issue_addr    <= '0;
      issue_data    <= '0;
      issue_rob_id  <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && wake1[i][32]) begin
          ent_q1[i] <= '0;
          ent_v1[i] <= wake1[i][31:0];
        end
        if (ent_valid[i] && wake2[i][32]) begin
          ent_q2[i] <= '0;
          ent_v2[i] <= wake2[i][31:0];
        end
        if (commit_hit[i]) ent_committed[i] <= 1'b1;
        if (flush && !keep[i]) begin
          ent_valid[i]     <= 1'b0;
          ent_committed[i] <= 1'b0;
        end
      end

      if (flush) begin
        tail  <= head + keep_count[AW-1:0];
        count <= keep_count;
        // A held store stays visible; a held load belongs to the squashed path.
        if (issue_ready || is_load(issue_op)) issue_valid <= 1'b0;
      end else begin
        if (do_issue) begin
          ent_valid[head]     <= 1'b0;
          ent_committed[head] <= 1'b0;
          head                <= head + AW'(1);
          issue_valid         <= 1'b1;
          issue_op            <= ent_op[head];
          issue_addr          <= head_addr;
          issue_data          <= ent_v2[head];
          issue_rob_id        <= ent_rob[head];
        end else if (issue_ready) begin
          issue_valid <= 1'b0;
        end
        if (do_alloc) begin
          ent_valid[tail]     <= 1'b1;
          ent_committed[tail] <= 1'b0;
          ent_op[tail]        <= in_op;
          ent_imm[tail]       <= in_imm;
          ent_rob[tail]       <= in_rob_id;
          ent_q1[tail]        <= byp1[32] ? '0 : in_q1;
          ent_v1[tail]        <= byp1[32] ? byp1[31:0] : in_v1;
          ent_q2[tail]        <= byp2[32] ? '0 : in_q2;
          ent_v2[tail]        <= byp2[32] ? byp2[31:0] : in_v2;
          tail                <= tail + AW'(1);
        end
        count <= count + CW'(do_alloc) - CW'(do_issue);
      end
    end
  end

endmodule

// File: tb/tb_ls_queue_multicdb.sv
// Bench for ls_queue_multicdb: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the entries and the issue register.
module tb_ls_queue_multicdb;
  localparam int          DEPTH       = 16;
  localparam int          ROB_W       = 4;
  localparam int          OP_W        = 6;
  localparam int          LOAD_OP_MAX = 5;
  localparam int          NUM_CDB     = 2;
  localparam int          FULL_MARGIN = 2;
  localparam logic [31:0] IO_ADDR     = 32'h30000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, rdy, in_valid, flush;
  logic [OP_W-1:0]          in_op;
  logic [31:0]              in_v1, in_v2, in_imm;
  logic [ROB_W-1:0]         in_q1, in_q2, in_rob_id;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     issue_valid, issue_ready;
  logic [OP_W-1:0]          issue_op;
  logic [31:0]              issue_addr, issue_data;
  logic [ROB_W-1:0]         issue_rob_id;
  logic                     commit_valid;
  logic [ROB_W-1:0]         commit_rob_id, io_rob_id_in, io_rob_id_out;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
  logic [NUM_CDB*32-1:0]    cdb_data;

  ls_queue_multicdb #(
    .DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .LOAD_OP_MAX(LOAD_OP_MAX),
    .NUM_CDB(NUM_CDB), .FULL_MARGIN(FULL_MARGIN), .IO_ADDR(IO_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_op(in_op),
    .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2), .in_imm(in_imm),
    .in_rob_id(in_rob_id), .full(full), .count(count), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_op(issue_op), .issue_addr(issue_addr),
    .issue_data(issue_data), .issue_rob_id(issue_rob_id), .commit_valid(commit_valid),
    .commit_rob_id(commit_rob_id), .io_rob_id_in(io_rob_id_in),
    .io_rob_id_out(io_rob_id_out), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_data(cdb_data), .flush(flush)
  );

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [31:0]      v1, v2, imm;
    logic [ROB_W-1:0] q1, q2, rob;
    logic             committed;
  } ent_t;

  ent_t             mq[$];
  logic             m_valid;
  logic [OP_W-1:0]  m_op;
  logic [31:0]      m_addr, m_data;
  logic [ROB_W-1:0] m_rob;
  int total = 0;
  int bad   = 0;

  function automatic logic is_ld(logic [OP_W-1:0] op);
    return int'(op) <= LOAD_OP_MAX;
  endfunction

  function automatic logic [32:0] bcast(logic [ROB_W-1:0] q);
    if (q == '0) return 33'd0;
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_valid[k] && cdb_rob_id[k*ROB_W +: ROB_W] == q) return {1'b1, cdb_data[k*32 +: 32]};
    return 33'd0;
  endfunction

  function automatic logic [ROB_W-1:0] exp_io();
    logic [31:0] a;
    if (mq.size() == 0) return '0;
    a = mq[0].v1 + mq[0].imm;
    if (is_ld(mq[0].op) && mq[0].q1 == '0 && a == IO_ADDR) return mq[0].rob;
    return '0;
  endfunction

  // One clock of the reference model, using the inputs as they stand before the edge.
  task automatic modelStep();
    ent_t h, e;
    logic can, take;
    logic [31:0] a;
    logic [32:0] w;
    int keep_n;
    if (rst) begin
      mq.delete();
      m_valid = 0; m_op = '0; m_addr = '0; m_data = '0; m_rob = '0;
      return;
    end
    if (!rdy) return;
    can = 0;
    a   = '0;
    if (mq.size() > 0) begin
      h = mq[0];
      a = h.v1 + h.imm;
      can = h.q1 == '0 && h.q2 == '0 && (!m_valid || issue_ready) && !flush &&
            (is_ld(h.op) ? (a != IO_ADDR || io_rob_id_in == h.rob) : h.committed);
    end
    if (flush) m_valid = m_valid && !issue_ready && !is_ld(m_op);
    else if (can) begin
      m_valid = 1; m_op = h.op; m_addr = a; m_data = h.v2; m_rob = h.rob;
    end else if (issue_ready) m_valid = 0;
    foreach (mq[i]) begin
      e = mq[i];
      if (commit_valid && e.rob == commit_rob_id) e.committed = 1;
      w = bcast(e.q1);
      if (w[32]) begin e.q1 = '0; e.v1 = w[31:0]; end
      w = bcast(e.q2);
      if (w[32]) begin e.q2 = '0; e.v2 = w[31:0]; end
      mq[i] = e;
    end
    if (flush) begin
      keep_n = 0;
      while (keep_n < mq.size() && !is_ld(mq[keep_n].op) && mq[keep_n].committed) keep_n++;
      while (mq.size() > keep_n) void'(mq.pop_back());
    end else begin
      take = in_valid && mq.size() < DEPTH;
      e.op = in_op; e.imm = in_imm; e.rob = in_rob_id; e.committed = 0;
      w = bcast(in_q1);
      e.q1 = w[32] ? '0 : in_q1;
      e.v1 = w[32] ? w[31:0] : in_v1;
      w = bcast(in_q2);
      e.q2 = w[32] ? '0 : in_q2;
      e.v2 = w[32] ? w[31:0] : in_v2;
      if (can) void'(mq.pop_front());
      if (take) mq.push_back(e);
    end
  endtask

  task automatic checkValue(string tag, logic [31:0] obs, logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic checkOutput();
    checkValue("count", 32'(count), mq.size());
    checkValue("full", 32'(full), 32'(mq.size() >= DEPTH - FULL_MARGIN));
    checkValue("issue_valid", 32'(issue_valid), 32'(m_valid));
    checkValue("issue_op", 32'(issue_op), 32'(m_op));
    checkValue("issue_addr", issue_addr, m_addr);
    checkValue("issue_data", issue_data, m_data);
    checkValue("issue_rob_id", 32'(issue_rob_id), 32'(m_rob));
    checkValue("io_rob_id_out", 32'(io_rob_id_out), 32'(exp_io()));
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic clearInputs();
    rdy = 1; in_valid = 0; flush = 0; commit_valid = 0; commit_rob_id = '0;
    io_rob_id_in = '0; cdb_valid = '0; cdb_rob_id = '0; cdb_data = '0;
    in_op = '0; in_v1 = '0; in_v2 = '0; in_imm = '0; in_q1 = '0; in_q2 = '0; in_rob_id = '0;
  endtask

  task automatic dispatch(logic [OP_W-1:0] op, logic [31:0] v1, logic [31:0] v2,
                          logic [31:0] imm, logic [ROB_W-1:0] q1, logic [ROB_W-1:0] q2,
                          logic [ROB_W-1:0] rob);
    in_valid = 1; in_op = op; in_v1 = v1; in_v2 = v2; in_imm = imm;
    in_q1 = q1; in_q2 = q2; in_rob_id = rob;
  endtask

  task automatic randomCycle();
    logic [ROB_W-1:0] id;
    logic used;
    int n;
    clearInputs();
    rdy = $urandom_range(0, 9) != 0;
    issue_ready = $urandom_range(0, 9) < 6;
    flush = $urandom_range(0, 49) == 0;
    if ($urandom_range(0, 9) < 5 && mq.size() < 12) begin
      id = ROB_W'($urandom_range(1, 15));
      used = 0;
      foreach (mq[i]) if (mq[i].rob == id) used = 1;
      if (!used) begin
        dispatch($urandom_range(0, 1) ? OP_W'($urandom_range(0, 5)) : OP_W'($urandom_range(6, 63)),
                 $urandom, $urandom, $urandom,
                 $urandom_range(0, 1) ? '0 : ROB_W'($urandom_range(1, 15)),
                 $urandom_range(0, 1) ? '0 : ROB_W'($urandom_range(1, 15)), id);
        if ($urandom_range(0, 6) == 0) begin in_v1 = IO_ADDR; in_imm = '0; end
      end
    end
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_valid[k] = $urandom_range(0, 9) < 4;
      cdb_rob_id[k*ROB_W +: ROB_W] = ROB_W'($urandom_range(1, 15));
      cdb_data[k*32 +: 32] = $urandom;
    end
    io_rob_id_in = $urandom_range(0, 1) ? exp_io() : ROB_W'($urandom_range(0, 15));
    // Commits arrive in order: only the first store past the committed-store prefix.
    n = 0;
    while (n < mq.size() && !is_ld(mq[n].op) && mq[n].committed) n++;
    if (n < mq.size() && !is_ld(mq[n].op) && $urandom_range(0, 2) == 0) begin
      commit_valid = 1;
      commit_rob_id = mq[n].rob;
    end
  endtask

  initial begin
    clearInputs();
    issue_ready = 0;
    rst = 1;
    applyStimulus();
    applyStimulus();
    rst = 0;
    checkValue("reset_count", 32'(count), 0);
    checkValue("reset_issue_valid", 32'(issue_valid), 0);
    checkValue("reset_full", 32'(full), 0);
    checkValue("reset_io", 32'(io_rob_id_out), 0);

    $display("[TB] plain load issue");
    issue_ready = 1;
    dispatch(6'd0, 32'h100, 32'h0, 32'h4, 4'd0, 4'd0, 4'd1);
    applyStimulus();
    clearInputs();
    checkValue("t1_count_after_dispatch", 32'(count), 1);
    applyStimulus();
    checkValue("t1_issue_valid", 32'(issue_valid), 1);
    checkValue("t1_issue_addr", issue_addr, 32'h104);
    checkValue("t1_count_after_issue", 32'(count), 0);
    applyStimulus();
    checkValue("t1_drained", 32'(issue_valid), 0);

    $display("[TB] store wakeup, commit and hold");
    issue_ready = 0;
    dispatch(6'd8, 32'h200, 32'h0, 32'h0, 4'd0, 4'd3, 4'd2);
    applyStimulus();
    clearInputs();
    cdb_valid = 2'b10; cdb_rob_id = {4'd3, 4'd0}; cdb_data = {32'hDEAD, 32'h0};
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkValue("t2_uncommitted_no_issue", 32'(issue_valid), 0);
    commit_valid = 1; commit_rob_id = 4'd2;
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkValue("t2_issue_valid", 32'(issue_valid), 1);
    checkValue("t2_issue_data", issue_data, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkValue("t2_hold_valid", 32'(issue_valid), 1);
      checkValue("t2_hold_data", issue_data, 32'hDEAD);
      checkValue("t2_hold_addr", issue_addr, 32'h200);
    end
    issue_ready = 1;
    applyStimulus();

    $display("[TB] IO load gating");
    dispatch(6'd2, IO_ADDR, 32'h0, 32'h0, 4'd0, 4'd0, 4'd5);
    applyStimulus();
    clearInputs();
    checkValue("t3_io_out", 32'(io_rob_id_out), 5);
    applyStimulus();
    checkValue("t3_no_issue", 32'(issue_valid), 0);
    io_rob_id_in = 4'd5;
    applyStimulus();
    clearInputs();
    checkValue("t3_issue_valid", 32'(issue_valid), 1);
    checkValue("t3_issue_rob", 32'(issue_rob_id), 5);
    checkValue("t3_io_cleared", 32'(io_rob_id_out), 0);
    applyStimulus();

    $display("[TB] fill to capacity");
    rst = 1;
    applyStimulus();
    rst = 0;
    issue_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(6'd1, 32'(i), 32'h0, 32'h0, 4'd9, 4'd0, ROB_W'(i + 1));
      applyStimulus();
      if (i == 12) checkValue("t4_full_at_13", 32'(full), 0);
      if (i == 13) checkValue("t4_full_at_14", 32'(full), 1);
    end
    checkValue("t4_count_full", 32'(count), DEPTH);
    dispatch(6'd1, 32'h0, 32'h0, 32'h0, 4'd9, 4'd0, 4'd1);
    applyStimulus();
    checkValue("t4_drop_count", 32'(count), DEPTH);
    clearInputs();
    flush = 1;
    applyStimulus();
    clearInputs();
    checkValue("t4_flush_count", 32'(count), 0);

    $display("[TB] flush keeps committed stores");
    issue_ready = 1;
    dispatch(6'd8, 32'h400, 32'hA1, 32'h0, 4'd0, 4'd0, 4'd1);
    applyStimulus();
    dispatch(6'd9, 32'h404, 32'hB2, 32'h0, 4'd0, 4'd0, 4'd2);
    applyStimulus();
    dispatch(6'd3, 32'h408, 32'h0, 32'h0, 4'd6, 4'd0, 4'd3);
    applyStimulus();
    dispatch(6'd10, 32'h40C, 32'hC4, 32'h0, 4'd0, 4'd0, 4'd4);
    applyStimulus();
    clearInputs();
    commit_valid = 1; commit_rob_id = 4'd1;
    applyStimulus();
    clearInputs();
    commit_valid = 1; commit_rob_id = 4'd2; flush = 1;
    applyStimulus();
    clearInputs();
    checkValue("t5_count_after_flush", 32'(count), 2);
    applyStimulus();
    checkValue("t5_first_data", issue_data, 32'hA1);
    checkValue("t5_first_addr", issue_addr, 32'h400);
    applyStimulus();
    checkValue("t5_second_data", issue_data, 32'hB2);
    checkValue("t5_count_empty", 32'(count), 0);
    applyStimulus();

    $display("[TB] dispatch-cycle CDB bypass");
    dispatch(6'd1, 32'h1234, 32'h0, 32'h10, 4'd7, 4'd0, 4'd8);
    cdb_valid = 2'b11; cdb_rob_id = {4'd7, 4'd7}; cdb_data = {32'h99, 32'h55};
    applyStimulus();
    clearInputs();
    applyStimulus();
    checkValue("t6_issue_valid", 32'(issue_valid), 1);
    checkValue("t6_issue_addr", issue_addr, 32'h65);
    applyStimulus();

    $display("[TB] random traffic");
    rst = 1;
    applyStimulus();
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      randomCycle();
      applyStimulus();
    end
    clearInputs();
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
